reduce_stim_driver: RTL and testbench
=====================================

Name: reduce_stim_driver

Overview:
- Active stimulus and self-check counterpart to the passive bound reduction monitor.
- Drives the reduction RTL's in1/in2 ports with every 2*WIDTH-bit input combination.
- Predicts out = (|in1) && (&in1), aligns the prediction to the DUT pipeline latency, compares it against the DUT's out, and reports pass/fail status plus the first failing vector.
- Instantiated in the simulation harness beside the DUT; never synthesised into product logic.

Parameters:
- WIDTH, 4, width of in1 and in2; legal range 2..8.
- LATENCY, 0, DUT cycles from in1/in2 to out; legal range 0..7.
- SEED, 1, nonzero LFSR seed; only used when REDUCE_STIM_LFSR_EN is defined.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- ASYNCRESETN  input  1  asynchronous active-low reset.
- start  input  1  single-cycle pulse; begins a run, honoured only in IDLE or DONE.
- dut_ready  input  1  DUT accepts the current vector when high; when low, the driver stalls.
- in1  output  WIDTH  stimulus to DUT in1.
- in2  output  WIDTH  stimulus to DUT in2.
- vec_valid  output  1  in1/in2 carry a live vector this cycle.
- dut_out  input  1  DUT out being checked.
- busy  output  1  high in RUN or DRAIN.
- done  output  1  high in DONE; held until the next start.
- pass  output  1  in DONE: high iff err_count == 0.
- err_count  output  16  mismatches seen; saturates at 16'hFFFF.
- first_fail  output  2*WIDTH  {in2,in1} of the first mismatching vector.

Behaviour:
- Reset (ASYNCRESETN low, effective immediately):
  - state=IDLE; in1, in2, vec_valid, busy, done, pass, err_count and first_fail all 0.
  - Delay line cleared, vector generator reloaded.
  - Reset mid-run abandons the run with no partial status.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE --start--> RUN.
  - RUN --last vector accepted--> DRAIN, or straight to DONE if LATENCY==0.
  - DRAIN --LATENCY cycles elapsed--> DONE.
  - DONE --start--> RUN.
  - Entering RUN clears err_count, first_fail and the delay line, and reloads the generator.
  - start seen while busy is ignored.
- Generator (default, macro undefined):
  - 2*WIDTH-bit counter cnt, starting at 0; in1 = cnt[WIDTH-1:0], in2 = cnt[2*WIDTH-1:WIDTH].
  - Advances only when vec_valid && dut_ready.
  - Last vector is the all-ones value; total 2^(2*WIDTH) vectors.
- Handshake and outputs:
  - vec_valid=1 throughout RUN; in1/in2 are registered outputs and hold stable while dut_ready=0.
  - vec_valid=0 in IDLE, DRAIN and DONE; in1/in2 hold their last values there.
- Expected value: exp = (|in1) && (&in1), computed from the accepted vector.
- Delay line:
  - LATENCY-deep shift register of {valid, exp, in2, in1}; shifts every cycle, independent of dut_ready.
  - Entry valid = vec_valid && dut_ready.
  - LATENCY==0: compare combinationally in the accept cycle.
- Compare:
  - At the delay-line tail, valid && (dut_out !== exp) is a mismatch; X/Z on dut_out counts as a mismatch.
  - A mismatch increments err_count (saturating).
  - On the first mismatch of a run, first_fail captures {in2,in1}.
- pass is valid only while done=1 and reads 0 otherwise.

Optional Feature:
- Macro: REDUCE_STIM_LFSR_EN.
- Defined:
  - Generator becomes a 2*WIDTH-bit Fibonacci LFSR loaded with SEED on entering RUN.
  - Taps by 2*WIDTH: 4:{4,3}, 6:{6,5}, 8:{8,6,5,4}, 10:{10,7}, 12:{12,6,4,1}, 14:{14,5,3,1}, 16:{16,15,13,4}.
  - Emits 2^(2*WIDTH)-1 nonzero states; the all-zero vector is issued once, last; total vector count unchanged.
  - Last-vector detection = zero vector accepted.
- Undefined: counter order as above; SEED ignored.

Test Plan:
- Correct DUT, WIDTH=4, LATENCY=0, dut_ready=1, start at cycle 0:
  - vectors 0x00..0xFF issued on consecutive cycles;
  - done rises 256 cycles after RUN entry; pass=1, err_count=0.
- Correct DUT with LATENCY=3 (DUT wrapped in a 3-stage pipe):
  - DRAIN lasts exactly 3 cycles; pass=1, err_count=0.
- DUT out forced to 0, LATENCY=0:
  - only in1=0xF gives exp=1, once per in2 value;
  - err_count=16, first_fail=8'h0F, pass=0.
- dut_ready toggled 1,0,0,1 repeating:
  - in1/in2 stable during the low cycles;
  - every vector is still checked exactly once; pass=1; 512 RUN cycles.
- ASYNCRESETN pulsed low at vector 0x40, then start:
  - all outputs read 0 immediately;
  - the new run restarts at vector 0x00, err_count=0.
- REDUCE_STIM_LFSR_EN, SEED=1, WIDTH=4:
  - first vector 0x01; zero vector is the 256th;
  - all 256 distinct vectors issued; pass=1.

Source files
------------

// File: rtl/reduce_stim_driver.sv
// reduce_stim_driver: exhaustive stimulus driver and self-checker for the
// reduction block out = (|in1) && (&in1). It walks every {in2,in1} vector,
// aligns its prediction to the DUT latency and reports pass/fail plus the
// first failing vector.
// Optional build macro REDUCE_STIM_LFSR_EN selects an LFSR vector order
// (seeded by SEED) instead of the default binary count.
module reduce_stim_driver #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned LATENCY = 0,
  parameter int unsigned SEED    = 1
) (
  input  logic               CLK,
  input  logic               ASYNCRESETN,
  input  logic               start,
  input  logic               dut_ready,
  output logic [WIDTH-1:0]   in1,
  output logic [WIDTH-1:0]   in2,
  output logic               vec_valid,
  input  logic               dut_out,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [15:0]        err_count,
  output logic [2*WIDTH-1:0] first_fail
);

  localparam int unsigned VW      = 2 * WIDTH;
  localparam int unsigned ENTRY_W = VW + 2;

  localparam int unsigned DRAIN_LAST_I = (LATENCY == 0) ? 0 : LATENCY - 1;
  localparam logic [2:0]  DRAIN_LAST   = DRAIN_LAST_I[2:0];

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [VW-1:0]      vec;
  logic [VW-1:0]      gen_next;
  logic               last_vec;
  logic               accept;
  logic               run_enter;
  logic               exp_now;
  logic [ENTRY_W-1:0] entry;
  logic [ENTRY_W-1:0] tail;
  logic               tail_valid;
  logic               tail_exp;
  logic [VW-1:0]      tail_vec;
  logic               mismatch;
  logic [2:0]         drain_cnt;

`ifdef REDUCE_STIM_LFSR_EN
  // Feedback tap masks for a maximal-length Fibonacci LFSR of n bits.
  function automatic logic [15:0] tap_mask(input int unsigned n);
    logic [15:0] m;
    case (n)
      4:       m = 16'h000C;
      6:       m = 16'h0030;
      8:       m = 16'h00B8;
      10:      m = 16'h0240;
      12:      m = 16'h0829;
      14:      m = 16'h2015;
      16:      m = 16'hD008;
      default: m = '0;
    endcase
    return m;
  endfunction

  localparam logic [15:0]   TAP_ALL  = tap_mask(VW);
  localparam logic [VW-1:0] TAPS     = TAP_ALL[VW-1:0];
  localparam logic [VW-1:0] GEN_INIT = SEED[VW-1:0];

  logic [VW-1:0] lfsr_step;

  // The LFSR never reaches zero; the step that would wrap back to the seed
  // emits the zero vector instead, so zero is issued exactly once, last.
  always_comb begin
    lfsr_step = {vec[VW-2:0], ^(vec & TAPS)};
    gen_next  = (lfsr_step == GEN_INIT) ? '0 : lfsr_step;
    last_vec  = (vec == '0);
  end
`else
  localparam logic [VW-1:0] GEN_INIT = '0;
  localparam logic [VW-1:0] ONE      = {{(VW-1){1'b0}}, 1'b1};

  // Binary count: the all-ones vector is the last one.
  always_comb begin
    gen_next = vec + ONE;
    last_vec = &vec;
  end
`endif

  assign in1       = vec[WIDTH-1:0];
  assign in2       = vec[VW-1:WIDTH];
  assign vec_valid = (state == S_RUN);
  assign busy      = (state == S_RUN) || (state == S_DRAIN);
  assign done      = (state == S_DONE);
  assign pass      = (state == S_DONE) && (err_count == '0);

  assign accept    = vec_valid && dut_ready;
  assign run_enter = start && ((state == S_IDLE) || (state == S_DONE));
  assign exp_now   = (|in1) && (&in1);
  assign entry     = {accept, exp_now, vec};

  // Delay line aligning each accepted vector with the DUT output.
  generate
    if (LATENCY == 0) begin : g_no_delay
      assign tail = entry;
    end else begin : g_delay
      logic [ENTRY_W-1:0] dl [LATENCY];

      // Shifts every cycle regardless of dut_ready; a new run starts empty.
      always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
          for (int unsigned i = 0; i < LATENCY; i++) dl[i] <= '0;
        end else if (run_enter) begin
          for (int unsigned i = 0; i < LATENCY; i++) dl[i] <= '0;
        end else begin
          dl[0] <= entry;
          for (int unsigned i = 1; i < LATENCY; i++) dl[i] <= dl[i-1];
        end
      end

      assign tail = dl[LATENCY-1];
    end
  endgenerate

  assign tail_valid = tail[ENTRY_W-1];
  assign tail_exp   = tail[ENTRY_W-2];
  assign tail_vec   = tail[VW-1:0];

  // Case inequality so an X/Z DUT output is reported as a mismatch.
  assign mismatch = tail_valid && (dut_out !== tail_exp);

  // State register.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) state <= S_IDLE;
    else              state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN: begin
        if (accept && last_vec) state_nxt = (LATENCY == 0) ? S_DONE : S_DRAIN;
      end
      S_DRAIN: if (drain_cnt == DRAIN_LAST) state_nxt = S_DONE;
      S_DONE:  if (start) state_nxt = S_RUN;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Vector register; holds on stall and after the last vector.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN)              vec <= '0;
    else if (run_enter)            vec <= GEN_INIT;
    else if (accept && !last_vec)  vec <= gen_next;
  end

  // Counts cycles spent in DRAIN.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN)           drain_cnt <= '0;
    else if (state == S_DRAIN)  drain_cnt <= drain_cnt + 3'd1;
    else                        drain_cnt <= '0;
  end

  // Mismatch bookkeeping: saturating count and first failing vector.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      err_count  <= '0;
      first_fail <= '0;
    end else if (run_enter) begin
      err_count  <= '0;
      first_fail <= '0;
    end else if (mismatch) begin
      if (err_count != '1) err_count <= err_count + 16'd1;
      if (err_count == '0) first_fail <= tail_vec;
    end
  end

endmodule

// File: tb/tb_reduce_stim_driver.sv
// Directed bench for reduce_stim_driver: two instances (LATENCY 0 and 3)
// share stimulus; each checks a behavioural reduction model.
module tb_reduce_stim_driver;

  localparam int unsigned W = 4;

  logic CLK = 1'b0;
  logic ASYNCRESETN;
  logic start;
  logic dut_ready;
  logic force0;

  logic [W-1:0]   in1_0, in2_0, in1_3, in2_3;
  logic           vv0, vv3, busy0, busy3, done0, done3, pass0, pass3;
  logic [15:0]    err0, err3;
  logic [2*W-1:0] ff0, ff3;
  logic           out0, out3;
  logic [2:0]     pipe3;

  int compared   = 0;
  int mismatched = 0;

  int n, run0, drain3, done0_at, done3_at, idx, distinct;
  bit aborted;
  bit got_f;
  logic [7:0] first_vec, last_acc, first_f;
  bit seen [256];

`ifdef REDUCE_STIM_LFSR_EN
  localparam logic [7:0] LAST_V = 8'h00;
`else
  localparam logic [7:0] LAST_V = 8'hFF;
`endif

  always #5 CLK = ~CLK;

  // Reduction DUT models: combinational (optionally stuck at 0) and 3-stage.
  assign out0 = force0 ? 1'b0 : ((|in1_0) && (&in1_0));
  always @(posedge CLK) pipe3 <= {pipe3[1:0], (|in1_3) && (&in1_3)};
  assign out3 = pipe3[2];

  reduce_stim_driver #(.WIDTH(W), .LATENCY(0), .SEED(1)) u_dut0 (
    .CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .start(start), .dut_ready(dut_ready),
    .in1(in1_0), .in2(in2_0), .vec_valid(vv0), .dut_out(out0), .busy(busy0),
    .done(done0), .pass(pass0), .err_count(err0), .first_fail(ff0)
  );

  reduce_stim_driver #(.WIDTH(W), .LATENCY(3), .SEED(1)) u_dut3 (
    .CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .start(start), .dut_ready(dut_ready),
    .in1(in1_3), .in2(in2_3), .vec_valid(vv3), .dut_out(out3), .busy(busy3),
    .done(done3), .pass(pass3), .err_count(err3), .first_fail(ff3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero();
    check("rst_in1", in1_0, 0);
    check("rst_in2", in2_0, 0);
    check("rst_vec_valid", vv0, 0);
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_pass", pass0, 0);
    check("rst_err_count", err0, 0);
    check("rst_first_fail", ff0, 0);
    check("rst_busy3", busy3, 0);
    check("rst_done3", done3, 0);
  endtask

  task automatic do_run(input bit toggle, input bit abort_at_40);
    logic [7:0] v;
    n = 0; run0 = 0; drain3 = 0; done0_at = -1; done3_at = -1;
    idx = 0; distinct = 0; aborted = 0; got_f = 0;
    first_vec = '0; last_acc = '0; first_f = '0;
    for (int i = 0; i < 256; i++) seen[i] = 0;
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    check("pass_low_in_run", pass0, 0);
    while ((done0_at < 0 || done3_at < 0) && n < 2000) begin
      v = {in2_0, in1_0};
      if (abort_at_40 && vv0 && v == 8'h40) begin
        ASYNCRESETN = 1'b0;
        #1;
        check_zero();
        aborted = 1;
        break;
      end
      dut_ready = toggle ? ((n % 4 == 0) || (n % 4 == 3)) : 1'b1;
      start     = (n == 100);
      if (vv0) begin
        run0++;
`ifdef REDUCE_STIM_LFSR_EN
        if (idx == 0) first_vec = v;
`else
        check("vector_order", v, idx[7:0]);
`endif
        if (dut_ready) begin
          if (!seen[v]) distinct++;
          seen[v] = 1;
          last_acc = v;
          if (!got_f && v[3:0] == 4'hF) begin
            got_f = 1;
            first_f = v;
          end
          idx++;
        end
      end
      if (busy3 && !vv3) drain3++;
      if (done0 && done0_at < 0) done0_at = n;
      if (done3 && done3_at < 0) done3_at = n;
      @(posedge CLK); #1;
      n++;
    end
    start = 1'b0;
    dut_ready = 1'b1;
    if (!abort_at_40) check("run_within_budget", n < 2000, 1);
  endtask

  initial begin
    ASYNCRESETN = 1'b0;
    start = 1'b0;
    dut_ready = 1'b1;
    force0 = 1'b0;
    #1;
    check_zero();
    #11;
    ASYNCRESETN = 1'b1;
    @(posedge CLK); #1;
    check("idle_no_start_busy", busy0, 0);

    // Run A: ready always high, stray start mid-run must be ignored.
    do_run(1'b0, 1'b0);
    check("a_run_cycles", run0, 256);
    check("a_done0_at", done0_at, 256);
    check("a_done3_at", done3_at, 259);
    check("a_drain3", drain3, 3);
    check("a_accepted", idx, 256);
    check("a_distinct", distinct, 256);
    check("a_last_vec", last_acc, LAST_V);
`ifdef REDUCE_STIM_LFSR_EN
    check("a_first_vec", first_vec, 8'h01);
`endif
    check("a_pass0", pass0, 1);
    check("a_err0", err0, 0);
    check("a_pass3", pass3, 1);
    check("a_err3", err3, 0);
    repeat (3) @(posedge CLK);
    #1;
    check("a_done_held", done0, 1);
    check("a_idle_busy", busy0, 0);
    check("a_idle_valid", vv0, 0);
    check("a_vec_hold", {in2_0, in1_0}, LAST_V);

    // Run B: DUT output stuck at 0 on the LATENCY=0 instance.
    force0 = 1'b1;
    do_run(1'b0, 1'b0);
    force0 = 1'b0;
    check("b_err0", err0, 16);
`ifdef REDUCE_STIM_LFSR_EN
    check("b_first_fail", ff0, first_f);
`else
    check("b_first_fail", ff0, 8'h0F);
`endif
    check("b_pass0", pass0, 0);
    check("b_done0_at", done0_at, 256);
    check("b_pass3", pass3, 1);
    check("b_err3", err3, 0);

    // Run C: dut_ready pattern 1,0,0,1.
    do_run(1'b1, 1'b0);
    check("c_run_cycles", run0, 512);
    check("c_done0_at", done0_at, 512);
    check("c_done3_at", done3_at, 515);
    check("c_drain3", drain3, 3);
    check("c_accepted", idx, 256);
    check("c_distinct", distinct, 256);
    check("c_pass0", pass0, 1);
    check("c_err0_cleared", err0, 0);
    check("c_ff0_cleared", ff0, 0);
    check("c_pass3", pass3, 1);

    // Run D: asynchronous reset at vector 0x40, then a fresh run.
    do_run(1'b0, 1'b1);
    check("d_aborted", aborted, 1);
    repeat (2) @(posedge CLK);
    #4;
    ASYNCRESETN = 1'b1;
    @(posedge CLK); #1;
    check("d_idle_after_reset", busy0, 0);
    do_run(1'b0, 1'b0);
    check("e_done0_at", done0_at, 256);
    check("e_accepted", idx, 256);
    check("e_pass0", pass0, 1);
    check("e_err0", err0, 0);
    check("e_pass3", pass3, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
